// File: rtl/calc_sequencer.sv
// Button-driven divider front end: synchronise/debounce buttons, build operands, launch a divide, show results.
// Press effect lands DEB_CYCLES+3 edges after BTN is first sampled high; div_start is a single-cycle request.
module calc_sequencer #(
  parameter int WIDTH      = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       BTN,
  output logic             div_start,
  output logic [WIDTH-1:0] div_num,
  output logic [WIDTH-1:0] div_den,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_rem,
  output logic [3:0]       LEDS
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [2:0] {NUM, DEN, RUN, WAIT, SHOW, ERR} state_t;

  logic [3:0]    s1, s2, deb, deb_q;
  logic [CW-1:0] cnt [4];

  // Level only moves after the synchronised input disagrees for DEB_CYCLES straight clocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1    <= BTN;
      s2    <= s1;
      deb_q <= deb;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] != deb[i]) begin
          if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
            deb[i] <= s2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  logic [3:0] ev;
  logic       ev_clr, ev_cfm, ev_inc, ev_view;

  assign ev      = deb & ~deb_q;
  assign ev_clr  = ev[3];
  assign ev_cfm  = ev[1] & ~ev[3];
  assign ev_inc  = ev[0] & ~ev[1] & ~ev[3];
  assign ev_view = ev[2] & ~ev[0] & ~ev[1] & ~ev[3];

  state_t           state, state_nxt;
  logic [WIDTH-1:0] num, den, quot, rem;
  logic [WIDTH-1:0] num_nxt, den_nxt, quot_nxt, rem_nxt;
  logic             view, view_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= NUM;
      num   <= '0;
      den   <= '0;
      quot  <= '0;
      rem   <= '0;
      view  <= 1'b0;
    end else begin
      state <= state_nxt;
      num   <= num_nxt;
      den   <= den_nxt;
      quot  <= quot_nxt;
      rem   <= rem_nxt;
      view  <= view_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    num_nxt   = num;
    den_nxt   = den;
    quot_nxt  = quot;
    rem_nxt   = rem;
    view_nxt  = view;
    if (ev_clr) begin
      state_nxt = NUM;
      num_nxt   = '0;
      den_nxt   = '0;
      quot_nxt  = '0;
      rem_nxt   = '0;
      view_nxt  = 1'b0;
    end else begin
      case (state)
        NUM: begin
          if (ev_inc) num_nxt = num + WIDTH'(1);
          if (ev_cfm) begin
            state_nxt = DEN;
            den_nxt   = '0;
          end
        end
        DEN: begin
          if (ev_inc) den_nxt = den + WIDTH'(1);
          if (ev_cfm) state_nxt = (den != '0) ? RUN : ERR;
        end
        RUN:  state_nxt = WAIT;
        WAIT: begin
          if (div_done) begin
            quot_nxt  = div_quot;
            rem_nxt   = div_rem;
            view_nxt  = 1'b0;
            state_nxt = SHOW;
          end
        end
        SHOW, ERR: begin
          if (ev_view && state == SHOW) view_nxt = ~view;
          if (ev_cfm) begin
            state_nxt = NUM;
            num_nxt   = '0;
            den_nxt   = '0;
          end
        end
        default: state_nxt = NUM;
      endcase
    end
  end

  assign div_start = (state == RUN);
  assign div_num   = num;
  assign div_den   = den;

  logic [WIDTH+3:0] ext;

  // Zero-extend then take the low nibble so any WIDTH maps onto the four LEDs.
  always_comb begin
    ext = '0;
    case (state)
      NUM:     ext[WIDTH-1:0] = num;
      DEN:     ext[WIDTH-1:0] = den;
      SHOW:    ext[WIDTH-1:0] = view ? rem : quot;
      default: ext = '0;
    endcase
    LEDS = (state == ERR) ? 4'hF : ext[3:0];
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: operand entry, divide handshake, error path, clear and reset behaviour.
module tb_calc_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] BTN;
  logic       div_start;
  logic [3:0] div_num, div_den;
  logic       div_done;
  logic [3:0] div_quot, div_rem;
  logic [3:0] LEDS;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic [3:0] cap_num = '0;
  logic [3:0] cap_den = '0;

  calc_sequencer #(.WIDTH(4), .DEB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .BTN(BTN),
    .div_start(div_start), .div_num(div_num), .div_den(div_den),
    .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem),
    .LEDS(LEDS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider-side monitor: counts start requests and latches the operands they carried.
  always @(posedge clk) begin
    if (div_start) begin
      start_cnt <= start_cnt + 1;
      cap_num   <= div_num;
      cap_den   <= div_den;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int b);
    BTN[b] = 1'b1;
    repeat (15) @(negedge clk);
    BTN[b] = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  task automatic press_n(input int b, input int n);
    for (int k = 0; k < n; k++) press(b);
  endtask

  task automatic divider_done();
    div_quot = (cap_den != 0) ? cap_num / cap_den : 4'h0;
    div_rem  = (cap_den != 0) ? cap_num % cap_den : 4'h0;
    div_done = 1'b1;
    @(negedge clk);
    div_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; BTN = '0; div_done = 1'b0; div_quot = '0; div_rem = '0;
    repeat (3) @(negedge clk);
    check("reset_leds", LEDS, 4'h0);
    check("reset_start", div_start, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Effect must appear exactly on the 7th edge after BTN is first sampled.
    BTN[0] = 1'b1;
    repeat (6) @(negedge clk);
    check("latency_before", LEDS, 4'h0);
    @(negedge clk);
    check("latency_at", LEDS, 4'h1);
    repeat (8) @(negedge clk);
    check("hold_single_event", LEDS, 4'h1);
    BTN[0] = 1'b0;
    repeat (15) @(negedge clk);
    check("release_no_event", LEDS, 4'h1);

    press_n(0, 3);
    check("four_incs", LEDS, 4'h4);

    BTN[0] = 1'b1;
    repeat (3) @(negedge clk);
    BTN[0] = 1'b0;
    repeat (15) @(negedge clk);
    check("glitch_ignored", LEDS, 4'h4);

    press(3);
    check("clear_num", LEDS, 4'h0);

    press_n(0, 7);
    check("num_7", LEDS, 4'h7);
    press(1);
    check("den_entry", LEDS, 4'h0);
    press_n(0, 2);
    check("den_2", LEDS, 4'h2);
    press(1);
    check("one_start", start_cnt, 1);
    check("start_num", cap_num, 4'h7);
    check("start_den", cap_den, 4'h2);
    check("wait_leds", LEDS, 4'h0);
    divider_done();
    check("show_quot", LEDS, 4'h3);
    press(2);
    check("show_rem", LEDS, 4'h1);
    press(2);
    check("show_quot_again", LEDS, 4'h3);
    check("num_held", div_num, 4'h7);
    check("den_held", div_den, 4'h2);
    check("still_one_start", start_cnt, 1);
    press(1);
    check("back_to_num", LEDS, 4'h0);

    press_n(0, 5);
    check("num_5", LEDS, 4'h5);
    press(1);
    press(1);
    check("err_leds", LEDS, 4'hF);
    check("err_no_start", start_cnt, 1);
    press(1);
    check("err_to_num", LEDS, 4'h0);

    press_n(0, 15);
    check("num_15", LEDS, 4'hF);
    press(0);
    check("wrap_to_0", LEDS, 4'h0);

    press(0);
    BTN[0] = 1'b1; BTN[3] = 1'b1;
    repeat (15) @(negedge clk);
    BTN = '0;
    repeat (15) @(negedge clk);
    check("clear_beats_inc", LEDS, 4'h0);

    press_n(0, 3);
    press(1);
    press(0);
    press(1);
    check("second_start", start_cnt, 2);
    press(3);
    check("clear_in_wait", LEDS, 4'h0);
    div_quot = 4'h9; div_rem = 4'h9; div_done = 1'b1;
    @(negedge clk);
    div_done = 1'b0;
    repeat (3) @(negedge clk);
    check("late_done_ignored", LEDS, 4'h0);
    press(0);
    check("state_is_num", LEDS, 4'h1);

    press(1);
    press(0);
    press(1);
    check("third_start", start_cnt, 3);
    divider_done();
    check("show_1_div_1", LEDS, 4'h1);
    #2 reset = 1'b0;
    #1 check("async_reset_leds", LEDS, 4'h0);
    check("async_reset_start", div_start, 1'b0);
    #1 reset = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_leds", LEDS, 4'h0);
    check("no_start_after_reset", start_cnt, 3);
    press(0);
    check("post_reset_num", LEDS, 4'h1);

    // Button held through reset must still wait out the full sync+debounce delay.
    BTN[0] = 1'b1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("held_in_reset", LEDS, 4'h0);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("held_before", LEDS, 4'h0);
    @(negedge clk);
    check("held_at", LEDS, 4'h1);
    BTN[0] = 1'b0;
    repeat (15) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 4, which sets the operand and result width in bits.
REQ-002 The block SHALL have the parameter DEB_CYCLES, default 4, which sets the number of consecutive stable clocks required to accept a button level change.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 SHALL force reset state immediately, independent of clk.
REQ-005 BTN  input  4  raw, unsynchronized buttons: [0] increment, [1] confirm, [2] view toggle, [3] clear.
REQ-006 div_start  output  1  one-cycle pulse requesting a division.
REQ-007 div_num  output  WIDTH  numerator presented to the divider.
REQ-008 div_den  output  WIDTH  denominator presented to the divider.
REQ-009 div_done  input  1  one-cycle pulse from the divider marking a valid result.
REQ-010 div_quot  input  WIDTH  quotient from the divider, valid when div_done=1.
REQ-011 div_rem  input  WIDTH  remainder from the divider, valid when div_done=1.
REQ-012 LEDS  output  4  user display (WIDTH LSBs; upper bits 0 if WIDTH<4).

Function
REQ-013 Each BTN bit SHALL pass through a 2-flop synchronizer, then a debouncer whose level changes only after the synchronized value has differed from it for DEB_CYCLES consecutive clocks.
REQ-014 A press event SHALL be a one-cycle pulse on a debounced 0->1 transition; holding a button SHALL produce exactly one event, and release SHALL produce none.
REQ-015 The press event SHALL occur DEB_CYCLES+2 rising edges after the first edge that samples BTN high, and its effect SHALL appear in registers and on LEDS on the following edge.
REQ-016 When several press events coincide, only the highest-priority event SHALL act (BTN[3] > BTN[1] > BTN[0] > BTN[2]); the others SHALL be discarded.
REQ-017 The FSM states SHALL be NUM, DEN, RUN, WAIT, SHOW and ERR.
REQ-018 NUM: BTN[0] SHALL increment the numerator register modulo 2^WIDTH (15->0 for WIDTH=4); BTN[1] SHALL transition to DEN with the denominator register cleared to 0; LEDS SHALL show the numerator.
REQ-019 DEN: BTN[0] SHALL increment the denominator modulo 2^WIDTH; BTN[1] with denominator != 0 SHALL transition to RUN; BTN[1] with denominator = 0 SHALL transition to ERR without asserting div_start; LEDS SHALL show the denominator.
REQ-020 RUN: the block SHALL assert div_start for exactly one cycle and then move to WAIT; LEDS SHALL be 0.
REQ-021 WAIT: on div_done=1 the block SHALL capture div_quot and div_rem, clear the view bit, and move to SHOW; LEDS SHALL be 0.
REQ-022 SHOW: LEDS SHALL show the quotient when view=0 and the remainder when view=1; BTN[2] SHALL toggle view; BTN[1] SHALL move to NUM with both operands cleared.
REQ-023 ERR: LEDS SHALL be all ones; BTN[1] SHALL move to NUM with both operands cleared.
REQ-024 In every state, BTN[3] SHALL move to NUM with the operands, captured results and view bit cleared.
REQ-025 Clear during WAIT SHALL abandon the operation, and any later div_done SHALL be ignored.
REQ-026 div_done SHALL be ignored in every state other than WAIT.
REQ-027 div_num and div_den SHALL continuously drive the operand registers, which SHALL stay constant from RUN through SHOW.
REQ-028 Button events without a defined action in the current state SHALL have no effect.

Reset
REQ-029 While reset=0, the state SHALL be NUM, all operand, result, view and debouncer registers SHALL be 0, and div_start and LEDS SHALL be 0.
REQ-030 After reset deasserts, a button already held high SHALL produce a press event only after the full synchronizer and debounce delay.
REQ-031 Reset asserted mid-operation, including in WAIT, SHALL abort the operation, and no div_start SHALL follow reset release until RUN is re-entered.

Verification
REQ-032 Reset then four separate 15-cycle BTN[0] pulses -> LEDS=4; a glitch on BTN[0] shorter than DEB_CYCLES -> no change.
REQ-033 Numerator 7, BTN[1], denominator 2, BTN[1] -> exactly one div_start with div_num=7 and div_den=2; a divider model returns done -> LEDS=3; BTN[2] -> LEDS=1; BTN[2] -> LEDS=3.
REQ-034 Numerator 5, BTN[1], BTN[1] with denominator 0 -> LEDS=1111 with no div_start; BTN[1] -> NUM with LEDS=0.
REQ-035 Sixteen BTN[0] presses in NUM -> LEDS wraps to 0; BTN[0] and BTN[3] pressed in the same cycle -> clear wins and LEDS=0.
REQ-036 BTN[3] in WAIT, then div_done -> state NUM with LEDS=0 and no result captured.
REQ-037 reset=0 pulsed asynchronously between clock edges in SHOW -> LEDS=0 immediately, and the state is NUM after release.
